adc_selftest_pkt_gen: RTL and testbench

- Self-test traffic source for the packet-control path.
- Produces 24 lanes of 36-bit words (three 12-bit samples per lane) in the same lane format as the ADC capture data.
- Also produces packet framing (vld/sof/eof).
- Sits directly upstream of the self-test/ADC data selector, which forwards these lanes in self-test mode.

---
 rtl/pktctrl_pkg.sv | 27 ++
 rtl/adc_selftest_lane_pat.sv | 54 +++++
 rtl/adc_selftest_pkt_gen.sv | 234 +++++++++++++++++++++++
 tb/tb_adc_selftest_pkt_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pktctrl_pkg.sv
// Shared encodings for the packet-control self-test path: pattern modes,
// packet-generator FSM states, lane geometry and the PRBS15 seed/step.
package pktctrl_pkg;

  localparam int NUM_LANES        = 24;
  localparam int SAMPLES_PER_LANE = 3;
  localparam int LFSR_W           = 15;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;

  // Pattern-mode encodings as seen on rf_pat_mode.
  localparam logic [1:0] PAT_CONST = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHK   = 2'd2;
  localparam logic [1:0] PAT_PRBS  = 2'd3;

  // Packet-generator FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // One step of the x^15 + x^14 + 1 Fibonacci LFSR (shift left, feedback in).
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[14] ^ s[13]};
  endfunction

endpackage

// File: rtl/adc_selftest_lane_pat.sv
// Combinational sample former for one lane: builds the three samples of a
// lane word from the shadowed pattern mode and the current pattern state.
module adc_selftest_lane_pat
  import pktctrl_pkg::*;
#(
  parameter int SAMPLE_W = 12
) (
  input  logic [4:0]                           lane_idx,
  input  logic [1:0]                           mode,
  input  logic [SAMPLE_W-1:0]                  pat_const,
  input  logic [SAMPLE_W-1:0]                  base,
  input  logic [SAMPLE_W-1:0]                  lfsr,
  input  logic                                 parity,
  output logic [SAMPLES_PER_LANE*SAMPLE_W-1:0] word
);

  localparam logic [11:0] CHK_EVEN = 12'hAAA;
  localparam logic [11:0] CHK_ODD  = 12'h555;

  // Value of one sample slot of this lane.
  function automatic logic [SAMPLE_W-1:0] form_sample(
    input logic [1:0]          f_mode,
    input logic [SAMPLE_W-1:0] f_const,
    input logic [SAMPLE_W-1:0] f_base,
    input logic [SAMPLE_W-1:0] f_lfsr,
    input logic                f_parity,
    input logic [4:0]          f_lane,
    input logic [1:0]          f_slot
  );
    logic [SAMPLE_W-1:0] ramp_off;
    logic [11:0]         prbs_mask;
    // 3*lane + slot; the ramp wraps modulo 2^SAMPLE_W with no saturation.
    ramp_off  = SAMPLE_W'({f_lane, 1'b0}) + SAMPLE_W'(f_lane) + SAMPLE_W'(f_slot);
    // Lane and slot are folded into PRBS samples so lanes stay distinguishable.
    prbs_mask = {f_lane, f_slot, 5'b0_0000};
    case (f_mode)
      PAT_CONST: form_sample = f_const;
      PAT_RAMP:  form_sample = f_base + ramp_off;
      PAT_CHK:   form_sample = f_parity ? SAMPLE_W'(CHK_ODD) : SAMPLE_W'(CHK_EVEN);
      default:   form_sample = f_lfsr ^ SAMPLE_W'(prbs_mask);
    endcase
  endfunction

  // Assemble the lane word, sample k in bits [k*SAMPLE_W +: SAMPLE_W].
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    word = '0;
    for (int k = 0; k < SAMPLES_PER_LANE; k++) begin
      word[k*SAMPLE_W +: SAMPLE_W] = form_sample(mode, pat_const, base, lfsr,
                                                 parity, lane_idx, 2'(k));
    end
  end

endmodule

// File: rtl/adc_selftest_pkt_gen.sv
// Self-test packet generator: emits framed packets of 24 x 36-bit lane words
// (constant / ramp / checkerboard / PRBS15) in ADC capture lane format.
// The FSM state describes what is currently on the registered outputs; the
// "eff_*" signals describe the beat being launched at the coming edge.
module adc_selftest_pkt_gen
  import pktctrl_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int LEN_W    = 16,
  parameter int GAP_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rf_pkt_gen_en,
  input  logic                  rf_96path_en,
  input  logic [1:0]            rf_pat_mode,
  input  logic [SAMPLE_W-1:0]   rf_pat_const,
  input  logic [LEN_W-1:0]      rf_pkt_len,
  input  logic [GAP_W-1:0]      rf_pkt_gap,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_0,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_1,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_2,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_3,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_4,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_5,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_6,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_7,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_8,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_9,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_10,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_11,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_12,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_13,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_14,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_15,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_16,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_17,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_18,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_19,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_20,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_21,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_22,
  output logic [3*SAMPLE_W-1:0] pkt_gen_data_23,
  output logic                  pkt_gen_vld,
  output logic                  pkt_gen_sof,
  output logic                  pkt_gen_eof,
  output logic                  pkt_gen_busy
);

  localparam int WORD_W     = SAMPLES_PER_LANE * SAMPLE_W;
  localparam int HALF_LANES = NUM_LANES / 2;

  // FSM and counters.
  logic [1:0]          state, state_nxt;
  logic [LEN_W-1:0]    beat_cnt;          // index of the beat on the outputs
  logic [GAP_W-1:0]    gap_cnt;

  // Pattern state: values the next launched beat will use.
  logic [SAMPLE_W-1:0] ramp_base;
  logic [LFSR_W-1:0]   lfsr;
  logic                parity;

  // Per-packet shadow configuration.
  logic [1:0]          sh_mode;
  logic [SAMPLE_W-1:0] sh_const;
  logic [LEN_W-1:0]    sh_len;
  logic                sh_96;

  // Launch control for the coming edge.
  logic                last_beat, gap_done, reseed, start_pkt, emit;
  logic [GAP_W:0]      gap_cnt_inc;
  logic [LEN_W-1:0]    next_idx;
  logic [1:0]          eff_mode;
  logic [SAMPLE_W-1:0] eff_const, eff_base, ramp_step;
  logic [LEN_W-1:0]    eff_len;
  logic                eff_96, eff_parity;
  logic [LFSR_W-1:0]   eff_lfsr;

  logic [WORD_W-1:0]   lane_word [NUM_LANES];
  logic [WORD_W-1:0]   lane_out  [NUM_LANES];
  logic [WORD_W-1:0]   data_q    [NUM_LANES];

  // Decide whether a beat is launched at the next edge and where the FSM goes.
  always_comb begin
    last_beat   = (beat_cnt == sh_len);
    gap_cnt_inc = {1'b0, gap_cnt} + (GAP_W+1)'(1);
    gap_done    = (gap_cnt_inc >= {1'b0, rf_pkt_gap});
    reseed      = (state == ST_IDLE) && rf_pkt_gen_en;
    start_pkt   = reseed
                || ((state == ST_RUN) && last_beat && rf_pkt_gen_en && (rf_pkt_gap == '0))
                || ((state == ST_GAP) && rf_pkt_gen_en && gap_done);
    emit        = start_pkt || ((state == ST_RUN) && !last_beat);

    state_nxt = state;
    case (state)
      ST_IDLE: if (rf_pkt_gen_en) state_nxt = ST_RUN;
      ST_RUN: begin
        if (last_beat) begin
          if (!rf_pkt_gen_en)         state_nxt = ST_IDLE;
          else if (rf_pkt_gap == '0)  state_nxt = ST_RUN;
          else                        state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!rf_pkt_gen_en)  state_nxt = ST_IDLE;
        else if (gap_done)   state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Configuration and pattern state seen by the beat being launched: a new
  // packet takes the live registers, later beats use the shadows.
  always_comb begin
    eff_mode   = start_pkt ? rf_pat_mode  : sh_mode;
    eff_const  = start_pkt ? rf_pat_const : sh_const;
    eff_len    = start_pkt ? rf_pkt_len   : sh_len;
    eff_96     = start_pkt ? rf_96path_en : sh_96;
    eff_base   = reseed ? '0 : ramp_base;
    eff_lfsr   = reseed ? LFSR_SEED : lfsr;
    eff_parity = start_pkt ? 1'b0 : parity;
    next_idx   = start_pkt ? '0 : beat_cnt + LEN_W'(1);
    ramp_step  = eff_96 ? SAMPLE_W'(SAMPLES_PER_LANE * NUM_LANES)
                        : SAMPLE_W'(SAMPLES_PER_LANE * HALF_LANES);
  end

  // One sample former per lane; upper lanes are forced to 0 in 48-path mode.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    adc_selftest_lane_pat #(.SAMPLE_W(SAMPLE_W)) u_lane_pat (
      .lane_idx  (5'(l)),
      .mode      (eff_mode),
      .pat_const (eff_const),
      .base      (eff_base),
      .lfsr      (eff_lfsr[SAMPLE_W-1:0]),
      .parity    (eff_parity),
      .word      (lane_word[l])
    );
    assign lane_out[l] = ((l < HALF_LANES) || eff_96) ? lane_word[l] : '0;
  end

  // FSM state, beat index and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (emit) beat_cnt <= next_idx;
      if (state != ST_GAP) gap_cnt <= '0;
      else                 gap_cnt <= gap_cnt_inc[GAP_W-1:0];
    end
  end

  // Shadow configuration, captured on every beat 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mode  <= PAT_CONST;
      sh_const <= '0;
      sh_len   <= '0;
      sh_96    <= 1'b0;
    end else if (start_pkt) begin
      sh_mode  <= rf_pat_mode;
      sh_const <= rf_pat_const;
      sh_len   <= rf_pkt_len;
      sh_96    <= rf_96path_en;
    end
  end

  // Pattern state advances only on launched beats and persists across packets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_base <= '0;
      lfsr      <= LFSR_SEED;
      parity    <= 1'b0;
    end else if (emit) begin
      ramp_base <= eff_base + ramp_step;
      lfsr      <= lfsr_next(eff_lfsr);
      parity    <= ~eff_parity;
    end
  end

  // Registered framing and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_gen_vld  <= 1'b0;
      pkt_gen_sof  <= 1'b0;
      pkt_gen_eof  <= 1'b0;
      pkt_gen_busy <= 1'b0;
    end else begin
      pkt_gen_vld  <= emit;
      pkt_gen_sof  <= start_pkt;
      pkt_gen_eof  <= emit && (next_idx == eff_len);
      pkt_gen_busy <= (state_nxt != ST_IDLE);
    end
  end

  // Registered lane words, zero whenever no beat is launched.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this lane array is a bank of output flops, not a RAM, so it is reset like any other register to keep outputs at 0 in reset.
    if (rst) begin
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) data_q[l] <= emit ? lane_out[l] : '0;
    end
  end

  assign pkt_gen_data_0  = data_q[0];
  assign pkt_gen_data_1  = data_q[1];
  assign pkt_gen_data_2  = data_q[2];
  assign pkt_gen_data_3  = data_q[3];
  assign pkt_gen_data_4  = data_q[4];
  assign pkt_gen_data_5  = data_q[5];
  assign pkt_gen_data_6  = data_q[6];
  assign pkt_gen_data_7  = data_q[7];
  assign pkt_gen_data_8  = data_q[8];
  assign pkt_gen_data_9  = data_q[9];
  assign pkt_gen_data_10 = data_q[10];
  assign pkt_gen_data_11 = data_q[11];
  assign pkt_gen_data_12 = data_q[12];
  assign pkt_gen_data_13 = data_q[13];
  assign pkt_gen_data_14 = data_q[14];
  assign pkt_gen_data_15 = data_q[15];
  assign pkt_gen_data_16 = data_q[16];
  assign pkt_gen_data_17 = data_q[17];
  assign pkt_gen_data_18 = data_q[18];
  assign pkt_gen_data_19 = data_q[19];
  assign pkt_gen_data_20 = data_q[20];
  assign pkt_gen_data_21 = data_q[21];
  assign pkt_gen_data_22 = data_q[22];
  assign pkt_gen_data_23 = data_q[23];

endmodule

// File: tb/tb_adc_selftest_pkt_gen.sv
// Scoreboard bench for adc_selftest_pkt_gen: stimulus pushes expected beats,
// a negedge monitor pops and compares whenever the generator presents vld.
module tb_adc_selftest_pkt_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_pkt_gen_en, rf_96path_en;
  logic [1:0]  rf_pat_mode;
  logic [11:0] rf_pat_const;
  logic [15:0] rf_pkt_len;
  logic [7:0]  rf_pkt_gap;
  logic [35:0] d [24];
  logic        vld, sof, eof, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              sof;
    logic              eof;
    int                gap;      // idle cycles expected before this beat, -1 = don't care
    logic [23:0][35:0] data;
    int                ha;       // hand-checked lane A (-1 none)
    logic [35:0]       hva;
    int                hb;       // hand-checked lane B (-1 none)
    logic [35:0]       hvb;
  } exp_t;

  exp_t exp_q[$];

  adc_selftest_pkt_gen dut (
    .clk(clk), .rst(rst),
    .rf_pkt_gen_en(rf_pkt_gen_en), .rf_96path_en(rf_96path_en),
    .rf_pat_mode(rf_pat_mode), .rf_pat_const(rf_pat_const),
    .rf_pkt_len(rf_pkt_len), .rf_pkt_gap(rf_pkt_gap),
    .pkt_gen_data_0(d[0]),   .pkt_gen_data_1(d[1]),   .pkt_gen_data_2(d[2]),
    .pkt_gen_data_3(d[3]),   .pkt_gen_data_4(d[4]),   .pkt_gen_data_5(d[5]),
    .pkt_gen_data_6(d[6]),   .pkt_gen_data_7(d[7]),   .pkt_gen_data_8(d[8]),
    .pkt_gen_data_9(d[9]),   .pkt_gen_data_10(d[10]), .pkt_gen_data_11(d[11]),
    .pkt_gen_data_12(d[12]), .pkt_gen_data_13(d[13]), .pkt_gen_data_14(d[14]),
    .pkt_gen_data_15(d[15]), .pkt_gen_data_16(d[16]), .pkt_gen_data_17(d[17]),
    .pkt_gen_data_18(d[18]), .pkt_gen_data_19(d[19]), .pkt_gen_data_20(d[20]),
    .pkt_gen_data_21(d[21]), .pkt_gen_data_22(d[22]), .pkt_gen_data_23(d[23]),
    .pkt_gen_vld(vld), .pkt_gen_sof(sof), .pkt_gen_eof(eof), .pkt_gen_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference sample value, written from the pattern definitions.
  function automatic logic [11:0] ref_sample(input int mode, input logic [11:0] cval,
                                             input int base, input logic [14:0] lf,
                                             input int beat, input int lane, input int slot);
    case (mode)
      0:       return cval;
      1:       return 12'((base + 3*lane + slot) % 4096);
      2:       return (beat % 2 == 0) ? 12'hAAA : 12'h555;
      default: return lf[11:0] ^ 12'(lane*128 + slot*32);
    endcase
  endfunction

  // Queue the expected beats of npkt packets started from IDLE (reseeded).
  task automatic push_packets(input int mode, input logic [11:0] cval, input int len,
                              input int gap, input logic p96, input int npkt);
    int          base = 0;
    logic [14:0] lf   = 15'h7FFF;
    exp_t        e;
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b <= len; b++) begin
        e.sof = (b == 0);
        e.eof = (b == len);
        e.gap = (b != 0) ? 0 : ((p == 0) ? -1 : gap);
        e.ha = -1; e.hva = '0; e.hb = -1; e.hvb = '0;
        for (int l = 0; l < 24; l++) begin
          if (!p96 && l >= 12) e.data[l] = '0;
          else e.data[l] = {ref_sample(mode, cval, base, lf, b, l, 2),
                            ref_sample(mode, cval, base, lf, b, l, 1),
                            ref_sample(mode, cval, base, lf, b, l, 0)};
        end
        exp_q.push_back(e);
        base = (base + (p96 ? 72 : 36)) % 4096;
        lf   = {lf[13:0], lf[14] ^ lf[13]};
      end
    end
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic [11:0] cval, input int len,
                         input int gap, input logic p96);
    rf_pat_mode  = mode;
    rf_pat_const = cval;
    rf_pkt_len   = 16'(len);
    rf_pkt_gap   = 8'(gap);
    rf_96path_en = p96;
  endtask

  // Raise en, check latency 1, drop en once the last sof (plus extra beats) is seen.
  task automatic go(input int npkt, input int extra_beats, input logic [1:0] mode_after);
    int sofs = 1;
    int budget = 0;
    rf_pkt_gen_en = 1'b1;
    @(posedge clk); #1;
    check("first_vld_latency", {61'd0, vld, sof, busy}, 64'h7);
    while (sofs < npkt && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
      if (sof) sofs++;
    end
    if (budget >= 5000) check("sof_wait_timeout", 64'(sofs), 64'(npkt));
    for (int i = 0; i < extra_beats; i++) begin @(posedge clk); #1; end
    rf_pkt_gen_en = 1'b0;
    rf_pat_mode   = mode_after;
  endtask

  task automatic wait_idle(input string name);
    int budget = 0;
    while ((busy || exp_q.size() != 0) && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
    end
    check({name, "_busy_clear"}, {63'd0, busy}, 64'd0);
    check({name, "_all_beats_seen"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compares each vld beat to the scoreboard head, idle cycles to zero.
  initial begin
    int                idle = 0;
    int                bad;
    exp_t              e;
    logic [23:0][35:0] act;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 24; l++) act[l] = d[l];
      if (rst) begin
        idle = 0;
      end else if (vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("sof", {63'd0, sof}, {63'd0, e.sof});
          check("eof", {63'd0, eof}, {63'd0, e.eof});
          if (e.gap >= 0) check("gap_cycles", 64'(idle), 64'(e.gap));
          bad = -1;
          for (int l = 0; l < 24; l++) if (bad < 0 && act[l] !== e.data[l]) bad = l;
          if (bad < 0) check("beat_data", {28'd0, act[0]}, {28'd0, e.data[0]});
          else check($sformatf("beat_data_lane%0d", bad), {28'd0, act[bad]}, {28'd0, e.data[bad]});
          if (e.ha >= 0) check($sformatf("hand_lane%0d", e.ha), {28'd0, act[e.ha]}, {28'd0, e.hva});
          if (e.hb >= 0) check($sformatf("hand_lane%0d", e.hb), {28'd0, act[e.hb]}, {28'd0, e.hvb});
        end
        idle = 0;
      end else begin
        check("idle_outputs_zero", {61'd0, |act, sof, eof}, 64'd0);
        idle++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rf_pkt_gen_en = 1'b0;
    set_cfg(2'd0, 12'h000, 0, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {60'd0, vld, sof, eof, busy}, 64'd0);
    check("reset_data", {28'd0, d[0] | d[23]}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {63'd0, vld | busy}, 64'd0);

    // Ramp, 96-path, len=3, gap=2, two packets.
    set_cfg(2'd1, 12'h000, 3, 2, 1'b1);
    push_packets(1, 12'h000, 3, 2, 1'b1, 2);
    exp_q[0].ha = 0;  exp_q[0].hva = 36'h002001000;
    exp_q[0].hb = 23; exp_q[0].hvb = 36'h047046045;
    exp_q[1].ha = 0;  exp_q[1].hva = 36'h04A049048;
    exp_q[4].ha = 0;  exp_q[4].hva = 36'h122121120;
    go(2, 0, 2'd1);
    wait_idle("ramp96");

    // Ramp, 48-path, single-beat packets with a 1-cycle gap.
    set_cfg(2'd1, 12'h000, 0, 1, 1'b0);
    push_packets(1, 12'h000, 0, 1, 1'b0, 2);
    exp_q[0].ha = 12; exp_q[0].hva = 36'h0;
    exp_q[0].hb = 0;  exp_q[0].hvb = 36'h002001000;
    exp_q[1].ha = 0;  exp_q[1].hva = 36'h026025024;
    exp_q[1].hb = 23; exp_q[1].hvb = 36'h0;
    go(2, 0, 2'd1);
    wait_idle("ramp48");

    // Checkerboard, len=2, back-to-back packets.
    set_cfg(2'd2, 12'h000, 2, 0, 1'b1);
    push_packets(2, 12'h000, 2, 0, 1'b1, 2);
    exp_q[0].ha = 0;  exp_q[0].hva = 36'hAAAAAAAAA;
    exp_q[1].ha = 5;  exp_q[1].hva = 36'h555555555;
    exp_q[2].ha = 23; exp_q[2].hva = 36'hAAAAAAAAA;
    exp_q[3].ha = 0;  exp_q[3].hva = 36'hAAAAAAAAA;
    go(2, 0, 2'd2);
    wait_idle("chk");

    // Constant, len=1, gap=3.
    set_cfg(2'd0, 12'h5A3, 1, 3, 1'b1);
    push_packets(0, 12'h5A3, 1, 3, 1'b1, 2);
    exp_q[3].ha = 17; exp_q[3].hva = 36'h5A35A35A3;
    go(2, 0, 2'd0);
    wait_idle("const");

    // PRBS15 from IDLE, 10 back-to-back packets of 100 beats.
    set_cfg(2'd3, 12'h000, 99, 0, 1'b1);
    push_packets(3, 12'h000, 99, 0, 1'b1, 10);
    exp_q[0].ha = 0; exp_q[0].hva = 36'hFBFFDFFFF;
    exp_q[0].hb = 1; exp_q[0].hvb = 36'hF3FF5FF7F;
    go(10, 0, 2'd3);
    wait_idle("prbs");

    // en dropped and mode changed at beat 1 of a len=7 ramp packet.
    set_cfg(2'd1, 12'h000, 7, 4, 1'b1);
    push_packets(1, 12'h000, 7, 4, 1'b1, 1);
    exp_q[7].ha = 0; exp_q[7].hva = 36'h1FA1F91F8;
    go(1, 1, 2'd2);
    wait_idle("en_drop");
    check("idle_after_drop", {62'd0, vld, busy}, 64'd0);

    // Asynchronous reset mid-packet, then restart with a reseeded ramp.
    set_cfg(2'd1, 12'h000, 7, 0, 1'b1);
    push_packets(1, 12'h000, 7, 0, 1'b1, 1);
    rf_pkt_gen_en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_ctrl", {60'd0, vld, sof, eof, busy}, 64'd0);
    check("async_reset_data", {28'd0, d[0] | d[23]}, 64'd0);
    exp_q.delete();
    rf_pkt_gen_en = 1'b0;
    set_cfg(2'd1, 12'h000, 1, 0, 1'b1);
    push_packets(1, 12'h000, 1, 0, 1'b1, 1);
    exp_q[0].ha = 0; exp_q[0].hva = 36'h002001000;
    @(posedge clk); #1;
    rst = 1'b0;
    go(1, 0, 2'd1);
    wait_idle("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
